// File: rtl/shift_frame_ctrl.sv
// Two-requester round-robin serializer controller: grants one source, then shifts its
// word out MSB-first with frame_start/done strobes and an optional idle gap.
module shift_frame_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sd,
    output logic             sd_en,
    output logic             frame_start,
    output logic             done,
    output logic             busy,
    output logic             owner
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             fs_q, fs_d;
    logic             done_q, done_d;
    logic             win;

    // A lone request wins; on a tie the requester that did not own the last frame wins.
    assign win = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        fs_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    state_d = StShift;
                    sreg_d  = win ? data1 : data0;
                    cnt_d   = CNT_LAST;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    fs_d    = 1'b1;
                    owner_d = win;
                    last_d  = win;
                end
            end
            StShift: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = StGap;
                        gcnt_d  = GAP_LAST;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gcnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
        end
    end

    assign sd_en       = (state_q == StShift);
    assign sd          = sd_en & sreg_q[WIDTH-1];
    assign busy        = (state_q != StIdle);
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign frame_start = fs_q;
    assign done        = done_q;
    assign owner       = owner_q;

endmodule

// File: doc/shift_frame_ctrl.md
# shift_frame_ctrl

Two-requester round-robin serializer controller. It arbitrates between two byte sources, loads the winner's word into an internal left-shift register, and streams it MSB-first on a single serial line with framing strobes. It sits in front of the serial shift-register datapath and is the only block that drives its serial data input, so it owns sequencing and sharing of that resource.

## Interface
Parameters:
- WIDTH, 8, bits per frame (≥2)
- GAP, 2, idle cycles inserted after each frame (≥0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- req0  in  1  requester 0 has a word ready; held high until gnt0
- data0  in  WIDTH  requester 0 word; stable while req0 high
- req1  in  1  requester 1 request
- data1  in  WIDTH  requester 1 word
- gnt0  out  1  one-cycle pulse: data0 captured
- gnt1  out  1  one-cycle pulse: data1 captured
- sd  out  1  serial data, MSB first; 0 when sd_en low
- sd_en  out  1  high during every valid serial bit
- frame_start  out  1  pulse on the first bit of a frame
- done  out  1  pulse in the cycle after the last bit
- busy  out  1  high whenever the FSM is not IDLE
- owner  out  1  requester of the current or most recent frame

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE: at a rising edge with req0|req1, select the winner, load sreg <= data_winner and cnt <= WIDTH-1, register gnt_winner=1 and owner=winner, then go to SHIFT. With no request, remain in IDLE.
- Arbitration: a single request always wins. On a tie, the requester other than last_owner wins. last_owner resets to 1, so req0 wins the first tie.
- SHIFT: sd=sreg[WIDTH-1] and sd_en=1. Each edge does sreg <= {sreg[WIDTH-2:0],1'b0} and cnt <= cnt-1. At the edge where cnt==0, go to GAP (GAP>0) or IDLE (GAP==0), and register done=1.
- GAP: count GAP cycles with sd_en=0 and busy=1, then go to IDLE.
- Requests are sampled only in IDLE. A req held through a frame is re-arbitrated at the next IDLE. A requester may keep req high with new data for back-to-back frames.
- frame_start is high in the first SHIFT cycle, coincident with gnt.

## Timing
- Reset (async, immediate): state=IDLE, sreg=0, cnt=0, last_owner=1. All outputs are 0: gnt0, gnt1, sd, sd_en, frame_start, done, busy, owner.
- Reset asserted mid-frame aborts the frame with no done pulse. After reset release, the first edge with a request starts a fresh frame.
- Request-to-first-bit latency: 1 edge. If req is sampled at edge E0, the cycle after E0 has gnt, frame_start, sd_en, and sd=data[WIDTH-1].
- A frame occupies exactly WIDTH sd_en cycles. done is high in the single cycle after the last bit.
- Minimum frame-start spacing is WIDTH+GAP+1 cycles, because one IDLE sampling cycle is always included.
- busy is high from the first SHIFT cycle through the last GAP cycle.
- gnt0 and gnt1 are never high together. gnt, frame_start and done are each exactly one cycle wide.
- sd is 0 whenever sd_en=0.

## Test plan
- Reset mid-frame: req0=1, data0=8'hA5, pull rst low after 3 bits -> all outputs go to 0 immediately with no done pulse. After release, req0 restarts and the full 1,0,1,0,0,1,0,1 frame is sent.
- Single requester: req0=1, data0=8'hA5 -> gnt0 and frame_start one cycle after the sampling edge. sd=1,0,1,0,0,1,0,1 over 8 sd_en cycles. done one cycle after the last bit, then 2 GAP cycles with busy=1, then busy=0.
- Tie fairness: req0=req1=1 held continuously, data0=8'hFF, data1=8'h00 -> frames alternate 0,1,0,1. owner toggles. Frame starts are 11 cycles apart.
- Requester 1 alone: req1=1, data1=8'h81 -> gnt1 only, owner=1, sd=1,0,0,0,0,0,0,1, and gnt0 stays 0.
- GAP=0 build: back-to-back req0 -> 9-cycle frame spacing. done coincides with the IDLE cycle and sd_en=0 in that cycle.
- Late request: req1 rises mid-frame while frame 0 is shifting -> no effect until IDLE. Then gnt1 occurs and its frame_start comes exactly GAP+1 cycles after done.
